// File: rtl/uart_rx_packet.sv
// ============================================================================
// Module      : uart_rx_packet
// Description : Frames a uart_rx_byte stream into SYNC/LEN/payload/CHK packets,
//               verifies the checksum and holds the payload until acknowledged.
//               Optional inter-byte timeout: UART_RX_PACKET_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_packet #(
    parameter int         MAX_LEN     = 16,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CLK = 8680
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data,
    input  logic              new_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              pkt_valid,
    output logic [7:0]        pkt_len,
    input  logic              pkt_ack,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_ovr,
    output logic              err_tmo
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_len     = 3'd1;
    localparam logic [2:0] c_st_payload = 3'd2;
    localparam logic [2:0] c_st_chk     = 3'd3;
    localparam logic [2:0] c_st_hold    = 3'd4;

    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_len;
    logic [7:0] r_sum;
    logic [7:0] r_idx;
    logic [7:0] r_pkt_len;
    logic       r_err_chk;
    logic       r_err_len;
    logic       r_err_ovr;
    logic       r_err_tmo;
    logic       w_len_bad;
    logic       w_tmo_hit;
    logic [7:0] r_buf [0:(1<<ADDR_W)-1];

    assign w_len_bad = (data == 8'd0) || (data > c_max_len);

`ifdef UART_RX_PACKET_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CLK) + 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CLK - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               w_in_frame;

    assign w_in_frame = (r_state == c_st_len) || (r_state == c_st_payload) ||
                        (r_state == c_st_chk);
    assign w_tmo_hit  = w_in_frame && !new_data && (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (new_data || !w_in_frame || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:
                if (new_data && (data == SYNC_BYTE)) w_state_nxt = c_st_len;
            c_st_len:
                if (new_data) w_state_nxt = w_len_bad ? c_st_idle : c_st_payload;
            c_st_payload:
                if (new_data && ((r_idx + 8'd1) == r_len)) w_state_nxt = c_st_chk;
            c_st_chk:
                if (new_data) w_state_nxt = (data == r_sum) ? c_st_hold : c_st_idle;
            c_st_hold:
                if (pkt_ack) w_state_nxt = c_st_idle;
            default:
                w_state_nxt = c_st_idle;
        endcase
        if (w_tmo_hit) w_state_nxt = c_st_idle;
    end

    // Error flags are rebuilt every cycle so each one is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= 8'd0;
            r_sum     <= 8'd0;
            r_idx     <= 8'd0;
            r_pkt_len <= 8'd0;
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_ovr <= 1'b0;
            r_err_tmo <= 1'b0;
        end else begin
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_ovr <= 1'b0;
            r_err_tmo <= w_tmo_hit;
            if (new_data) begin
                case (r_state)
                    c_st_len: begin
                        if (w_len_bad) begin
                            r_err_len <= 1'b1;
                        end else begin
                            r_len <= data;
                            r_sum <= data;
                            r_idx <= 8'd0;
                        end
                    end
                    c_st_payload: begin
                        r_sum <= r_sum + data;
                        r_idx <= r_idx + 8'd1;
                    end
                    c_st_chk: begin
                        if (data == r_sum) r_pkt_len <= r_len;
                        else               r_err_chk <= 1'b1;
                    end
                    c_st_hold: r_err_ovr <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (new_data && (r_state == c_st_payload)) begin
            r_buf[r_idx[ADDR_W-1:0]] <= data;
        end
    end

    always_comb begin
        pkt_valid = (r_state == c_st_hold);
        pkt_len   = r_pkt_len;
        err_chk   = r_err_chk;
        err_len   = r_err_len;
        err_ovr   = r_err_ovr;
        err_tmo   = r_err_tmo;
        rd_data   = 8'h00;
        if ({{(9-ADDR_W){1'b0}}, rd_addr} < {1'b0, r_pkt_len}) begin
            rd_data = r_buf[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_packet.sv
// ============================================================================
// Module      : tb_uart_rx_packet
// Description : Scoreboard bench for uart_rx_packet: stimulus queues expected
//               events, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_packet;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       new_data = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       pkt_valid;
    logic [7:0] pkt_len;
    logic       pkt_ack = 1'b0;
    logic       err_chk;
    logic       err_len;
    logic       err_ovr;
    logic       err_tmo;

    uart_rx_packet dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .new_data (new_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pkt_valid(pkt_valid),
        .pkt_len  (pkt_len),
        .pkt_ack  (pkt_ack),
        .err_chk  (err_chk),
        .err_len  (err_len),
        .err_ovr  (err_ovr),
        .err_tmo  (err_tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] kind;
        logic [7:0] len;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] tx[$];
    int         total = 0;
    int         bad = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input logic [7:0] kind, input logic [7:0] len);
        ev_t e;
        e.kind = kind;
        e.len  = len;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        @(posedge clk);
        #1;
        data     = b;
        new_data = 1'b1;
        @(posedge clk);
        #1;
        new_data = 1'b0;
    endtask

    task automatic send_tx();
        foreach (tx[i]) strobe(tx[i]);
    endtask

    // tx holds a complete good frame; bytes from 'start' onwards are sent here.
    task automatic good_frame(input int start);
        int n;
        n = tx.size();
        expect_ev("V", tx[1]);
        for (int i = start; i < n - 1; i++) strobe(tx[i]);
        check("valid_before_chk", pkt_valid, 1'b0);
        strobe(tx[n-1]);
        check("valid_after_chk", pkt_valid, 1'b1);
        check("pkt_len", pkt_len, tx[1]);
        for (int i = 0; i <= int'(tx[1]); i++) begin
            rd_addr = 4'(i);
            #1;
            check("rd_data", rd_data, (i < int'(tx[1])) ? tx[2+i] : 8'h00);
        end
        rd_addr = 4'd0;
    endtask

    task automatic ack();
        @(posedge clk);
        #1;
        pkt_ack = 1'b1;
        @(posedge clk);
        #1;
        pkt_ack = 1'b0;
        check("valid_after_ack", pkt_valid, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        int         n;
        logic [7:0] k;
        ev_t        e;
        n = 0;
        k = 8'h00;
        if (err_chk === 1'b1) begin n++; k = "C"; end
        if (err_len === 1'b1) begin n++; k = "L"; end
        if (err_ovr === 1'b1) begin n++; k = "O"; end
        if (err_tmo === 1'b1) begin n++; k = "T"; end
        if (pkt_valid === 1'b1 && !prev_valid) begin n++; k = "V"; end
        prev_valid = (pkt_valid === 1'b1);
        if (n > 1) begin
            check("single_event", n, 1);
        end else if (n == 1) begin
            if (sb.size() == 0) begin
                check("unexpected_event", k, 8'h00);
            end else begin
                e = sb.pop_front();
                check("event_kind", k, e.kind);
                if (k == "V") check("event_len", pkt_len, e.len);
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        tick(3);
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_len", pkt_len, 8'h00);
        check("rst_errs", {err_chk, err_len, err_ovr, err_tmo}, 4'h0);
        check("rst_rd", rd_data, 8'h00);
        rst = 1'b0;
        tick(2);

        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        good_frame(0);
        ack();

        expect_ev("C", 8'h00);
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
        send_tx();
        tick(2);
        check("valid_after_bad_chk", pkt_valid, 1'b0);
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        good_frame(0);
        ack();

        expect_ev("L", 8'h00);
        tx = '{8'hA5, 8'h00};
        send_tx();
        expect_ev("L", 8'h00);
        tx = '{8'hA5, 8'h11};
        send_tx();
        tick(2);
        tx = '{8'hA5, 8'h01, 8'h44, 8'h45};
        good_frame(0);

        // Overrun while holding: buffer and length must not move.
        expect_ev("O", 8'h00);
        strobe(8'h5A);
        expect_ev("O", 8'h00);
        strobe(8'hA5);
        tick(1);
        check("hold_valid", pkt_valid, 1'b1);
        check("hold_len", pkt_len, 8'h01);
        check("hold_rd0", rd_data, 8'h44);
        expect_ev("O", 8'h00);
        @(posedge clk);
        #1;
        pkt_ack  = 1'b1;
        new_data = 1'b1;
        data     = 8'h33;
        @(posedge clk);
        #1;
        pkt_ack  = 1'b0;
        new_data = 1'b0;
        check("valid_after_ack_ovr", pkt_valid, 1'b0);
        // SYNC dropped in HOLD is not remembered: these bytes must be ignored.
        tx = '{8'h01, 8'h44, 8'h45};
        send_tx();
        tick(2);
        check("no_resync_valid", pkt_valid, 1'b0);

        tx = '{8'h00, 8'hFF, 8'h7E};
        send_tx();
        tx = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        good_frame(0);
        ack();

        tx = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h35};
        for (int i = 0; i < 3; i++) strobe(tx[i]);
`ifdef UART_RX_PACKET_TIMEOUT_EN
        expect_ev("T", 8'h00);
        tick(8700);
        tx = '{8'hA5, 8'h01, 8'h44, 8'h45};
        good_frame(0);
`else
        tick(8700);
        good_frame(3);
`endif
        ack();

        tx = '{8'hA5, 8'h03, 8'h11};
        send_tx();
        #2 rst = 1'b1;
        #1;
        check("arst_len", pkt_len, 8'h00);
        check("arst_valid", pkt_valid, 1'b0);
        check("arst_errs", {err_chk, err_len, err_ovr, err_tmo}, 4'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        good_frame(0);
        ack();

        tick(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
